// File: rtl/bfs_mem_read_bridge.sv
// bfs_mem_read_bridge
// Word-read front end for the BFS engine. Each 32-bit word request is turned
// into an AXI4 INCR read. The selected word comes back as a one-cycle
// rsp_valid pulse.
//
// Build option BFS_LINE_CACHE_EN:
//   defined   - fetch the whole enclosing line (LINE_BEATS x 64 bit) and keep
//               it with its tag. A request to the same line is then served
//               in one cycle with no AXI traffic.
//   undefined - single-beat fetch of the 8-byte word pair on every request.
//               There is no line buffer and flush is ignored.
//
// state  | meaning
// S_IDLE | req_ready high; accept a request and resolve hit/miss
// S_AR   | arvalid high; address/len held until arready
// S_DATA | rready high; collecting beats until rlast
// S_RESP | rsp_valid pulse; line validity/tag committed after a fill
module bfs_mem_read_bridge #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int LINE_BEATS     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   input  logic [31:0]               req_addr,
   output logic                      req_ready,
   output logic                      rsp_valid,
   output logic [31:0]               rsp_data,
   output logic                      rsp_err,
   input  logic                      flush,
   output logic                      busy,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);

   localparam int LINE_BYTES = 8 * LINE_BEATS;
   localparam int OFF_W      = $clog2(LINE_BYTES);
   localparam int BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
   localparam int TAG_W      = AXI_ADDR_WIDTH - OFF_W;
`ifdef BFS_LINE_CACHE_EN
   localparam logic [7:0] LAST_BEAT = 8'(LINE_BEATS - 1);
`else
   localparam logic [7:0] LAST_BEAT = 8'd0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA, S_RESP} state_t;

   state_t                    state_q;
   logic [7:0]                beat_q;
   logic                      err_q;
   logic                      lane_q;
   logic [AXI_ADDR_WIDTH-1:0] req_addr_t;
   logic                      err_fin;
   logic                      unused_sig;

   assign m_axi_arsize  = 3'd3;
   assign m_axi_arburst = 2'b01;
   assign req_addr_t    = AXI_ADDR_WIDTH'(req_addr);

   // error status as it stands once the current beat is the last one
   assign err_fin = err_q | m_axi_rresp[1] | (beat_q != LAST_BEAT);

   function automatic logic [31:0] word_lane(input logic [AXI_DATA_WIDTH-1:0] beat,
                                             input logic hi);
      return hi ? beat[63:32] : beat[31:0];
   endfunction

`ifdef BFS_LINE_CACHE_EN
   logic [AXI_DATA_WIDTH-1:0] line_buf [LINE_BEATS];
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [TAG_W-1:0]          tag_q;
   logic                      line_valid_q;
   logic                      flush_pending_q;
   logic                      fill_q;
   logic [BEAT_W-1:0]         req_sel;
   logic [BEAT_W-1:0]         addr_sel;
   logic                      hit;

   assign req_sel  = req_addr_t[3 +: BEAT_W] & BEAT_W'(LINE_BEATS - 1);
   assign addr_sel = addr_q[3 +: BEAT_W] & BEAT_W'(LINE_BEATS - 1);
   assign hit      = line_valid_q && (tag_q == req_addr_t[AXI_ADDR_WIDTH-1:OFF_W]);

   assign unused_sig = ^{req_addr_t[1:0], addr_q[2:0], m_axi_rresp[0]};

   // Line buffer fill; beats past the end of the line are dropped
   always_ff @(posedge clk) begin
      if (state_q == S_DATA && m_axi_rvalid && beat_q < 8'(LINE_BEATS))
         line_buf[beat_q[BEAT_W-1:0]] <= m_axi_rdata;
   end
`else
   assign unused_sig = ^{req_addr_t[1:0], m_axi_rresp[0], flush};
`endif

   // Control FSM, AXI handshakes, response registers and line validity
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         req_ready     <= 1'b1;
         busy          <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_err       <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arlen   <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         beat_q        <= '0;
         err_q         <= 1'b0;
         lane_q        <= 1'b0;
`ifdef BFS_LINE_CACHE_EN
         addr_q          <= '0;
         tag_q           <= '0;
         line_valid_q    <= 1'b0;
         flush_pending_q <= 1'b0;
         fill_q          <= 1'b0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  lane_q    <= req_addr_t[2];
                  err_q     <= 1'b0;
                  beat_q    <= '0;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
`ifdef BFS_LINE_CACHE_EN
                  addr_q          <= req_addr_t;
                  flush_pending_q <= 1'b0;
                  if (hit) begin
                     state_q   <= S_RESP;
                     fill_q    <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_data  <= word_lane(line_buf[req_sel], req_addr_t[2]);
                  end else begin
                     state_q       <= S_AR;
                     fill_q        <= 1'b1;
                     m_axi_arvalid <= 1'b1;
                     m_axi_araddr  <= {req_addr_t[AXI_ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                     m_axi_arlen   <= LAST_BEAT;
                  end
`else
                  state_q       <= S_AR;
                  m_axi_arvalid <= 1'b1;
                  m_axi_araddr  <= {req_addr_t[AXI_ADDR_WIDTH-1:3], 3'b000};
                  m_axi_arlen   <= LAST_BEAT;
`endif
               end
            end
            S_AR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state_q       <= S_DATA;
               end
            end
            S_DATA: begin
               if (m_axi_rvalid) begin
                  beat_q <= (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
`ifdef BFS_LINE_CACHE_EN
                  // the wanted word is taken as its beat is written to the buffer
                  if (beat_q == 8'(addr_sel))
                     rsp_data <= word_lane(m_axi_rdata, lane_q);
`else
                  if (m_axi_rlast)
                     rsp_data <= word_lane(m_axi_rdata, lane_q);
`endif
                  if (m_axi_rlast) begin
                     err_q        <= err_fin;
                     rsp_err      <= err_fin;
                     rsp_valid    <= 1'b1;
                     m_axi_rready <= 1'b0;
                     state_q      <= S_RESP;
                  end else if (m_axi_rresp[1]) begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_RESP: begin
               state_q   <= S_IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
`ifdef BFS_LINE_CACHE_EN
               if (fill_q) begin
                  tag_q        <= addr_q[AXI_ADDR_WIDTH-1:OFF_W];
                  line_valid_q <= !err_q && !flush_pending_q;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
`ifdef BFS_LINE_CACHE_EN
         // flush wins over any validity update made above in the same cycle
         if (flush) begin
            line_valid_q <= 1'b0;
            if (state_q == S_AR || state_q == S_DATA)
               flush_pending_q <= 1'b1;
         end
`endif
      end
   end

endmodule
